cordic_arbiter: RTL and testbench

Round-robin scheduler that shares a single `cordic` rotation core among `N_REQ` requesters. Each requester presents an angle with a valid/ready handshake. The block grants one requester at a time, clamps the angle to the core's legal range, pulses the core's start, waits for done (with a timeout), and returns cos/sin tagged with the requester ID through a backpressured result port. Only one transaction is outstanding at a time, so the core is only ever started while idle.

---
 rtl/cordic_arbiter.sv | 212 +++++++++++++++++++++
 tb/tb_cordic_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_arbiter.sv
// Round-robin scheduler sharing one CORDIC rotation core among N_REQ requesters.
// One transaction in flight at a time: grant, clamp, start, wait (with timeout), hold result.
module cordic_arbiter #(
  parameter int WL      = 16,
  parameter int N_REQ   = 4,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 64,
  parameter int PI_2    = 25736
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid_i,
  input  logic [N_REQ*WL-1:0]     req_angle_i,
  output logic [N_REQ-1:0]        req_ready_o,
  output logic                    res_valid_o,
  input  logic                    res_ready_i,
  output logic [ID_W-1:0]         res_id_o,
  output logic signed [WL-1:0]    res_cos_o,
  output logic signed [WL-1:0]    res_sin_o,
  output logic                    res_clamped_o,
  output logic                    res_timeout_o,
  output logic                    core_start_o,
  output logic signed [WL-1:0]    core_angle_o,
  input  logic signed [WL-1:0]    core_cos_i,
  input  logic signed [WL-1:0]    core_sin_i,
  input  logic                    core_done_i,
  output logic                    busy_o
);

  localparam int TW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [ID_W-1:0]      last_grant_q, last_grant_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [ID_W-1:0]      res_id_q, res_id_d;
  logic signed [WL-1:0] res_cos_q, res_cos_d;
  logic signed [WL-1:0] res_sin_q, res_sin_d;
  logic                 res_clamped_q, res_clamped_d;
  logic                 res_timeout_q, res_timeout_d;
  logic signed [WL-1:0] core_angle_q, core_angle_d;
  logic                 core_start_q, core_start_d;
  logic                 res_valid_q, res_valid_d;
  logic                 busy_q, busy_d;

  logic [ID_W-1:0]      grant_s;
  logic                 found_s;
  logic signed [WL-1:0] sel_angle_s;

  // Saturate an angle into [-PI_2, +PI_2]; MSB of the result flags a clamp.
  function automatic logic [WL:0] clamp_angle(input logic signed [WL-1:0] a);
    logic signed [WL-1:0] pos;
    logic signed [WL-1:0] neg;
    pos = PI_2[WL-1:0];
    neg = -pos;
    if (a > pos) begin
      return {1'b1, pos};
    end else if (a < neg) begin
      return {1'b1, neg};
    end else begin
      return {1'b0, a};
    end
  endfunction

  // Round-robin pick: first valid requester scanning upward from last_grant+1.
  always_comb begin
    int              idx;
    logic [ID_W-1:0] idx_w;
    grant_s = '0;
    found_s = 1'b0;
    idx     = 0;
    idx_w   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = int'(last_grant_q) + 1 + i;
      if (idx >= N_REQ) begin
        idx = idx - N_REQ;
      end else begin
        idx = idx;
      end
      idx_w = idx[ID_W-1:0];
      if (!found_s && req_valid_i[idx_w]) begin
        grant_s = idx_w;
        found_s = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

  assign sel_angle_s = req_angle_i[int'(grant_s)*WL +: WL];

  // Grant is combinational so the requester sees acceptance in the same cycle.
  always_comb begin
    req_ready_o = '0;
    if (rst_n && (state_q == ST_IDLE) && found_s) begin
      req_ready_o[grant_s] = 1'b1;
    end else begin
      req_ready_o = '0;
    end
  end

  // Next-state and datapath updates for the transaction FSM.
  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    timer_d       = timer_q;
    res_id_d      = res_id_q;
    res_cos_d     = res_cos_q;
    res_sin_d     = res_sin_q;
    res_clamped_d = res_clamped_q;
    res_timeout_d = res_timeout_q;
    core_angle_d  = core_angle_q;
    case (state_q)
      ST_IDLE: begin
        if (found_s) begin
          res_id_d                      = grant_s;
          last_grant_d                  = grant_s;
          {res_clamped_d, core_angle_d} = clamp_angle(sel_angle_s);
          state_d                       = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        timer_d = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        timer_d = timer_q + TW'(1);
        // A done arriving on the final timer cycle still delivers real data.
        if (core_done_i) begin
          res_cos_d     = core_cos_i;
          res_sin_d     = core_sin_i;
          res_timeout_d = 1'b0;
          state_d       = ST_HOLD;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          res_cos_d     = '0;
          res_sin_d     = '0;
          res_timeout_d = 1'b1;
          state_d       = ST_HOLD;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_HOLD: begin
        if (res_ready_i) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Status flags are registered off the next state so they are glitch-free.
  always_comb begin
    core_start_d = (state_d == ST_ISSUE);
    res_valid_d  = (state_d == ST_HOLD);
    busy_d       = (state_d != ST_IDLE);
  end

  // State and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      last_grant_q  <= ID_W'(N_REQ - 1);
      timer_q       <= '0;
      res_id_q      <= '0;
      res_cos_q     <= '0;
      res_sin_q     <= '0;
      res_clamped_q <= 1'b0;
      res_timeout_q <= 1'b0;
      core_angle_q  <= '0;
      core_start_q  <= 1'b0;
      res_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      timer_q       <= timer_d;
      res_id_q      <= res_id_d;
      res_cos_q     <= res_cos_d;
      res_sin_q     <= res_sin_d;
      res_clamped_q <= res_clamped_d;
      res_timeout_q <= res_timeout_d;
      core_angle_q  <= core_angle_d;
      core_start_q  <= core_start_d;
      res_valid_q   <= res_valid_d;
      busy_q        <= busy_d;
    end
  end

  assign res_valid_o   = res_valid_q;
  assign res_id_o      = res_id_q;
  assign res_cos_o     = res_cos_q;
  assign res_sin_o     = res_sin_q;
  assign res_clamped_o = res_clamped_q;
  assign res_timeout_o = res_timeout_q;
  assign core_start_o  = core_start_q;
  assign core_angle_o  = core_angle_q;
  assign busy_o        = busy_q;

endmodule

// File: tb/tb_cordic_arbiter.sv
// Scoreboard bench for cordic_arbiter with a behavioural 17-cycle core stub
// and a bench-side round-robin / timing model.
module tb_cordic_arbiter;

  localparam int WL = 16;
  localparam int NR = 4;
  localparam int TO = 64;
  localparam int PI2 = 25736;

  logic                 clk;
  logic                 rst_n;
  logic [NR-1:0]        req_valid;
  logic [NR*WL-1:0]     req_angle;
  logic [NR-1:0]        req_ready;
  logic                 res_valid;
  logic                 res_ready;
  logic [1:0]           res_id;
  logic signed [WL-1:0] res_cos, res_sin;
  logic                 res_clamped, res_timeout;
  logic                 core_start;
  logic signed [WL-1:0] core_angle;
  logic signed [WL-1:0] core_cos, core_sin;
  logic                 core_done;
  logic                 busy;

  cordic_arbiter #(.WL(WL), .N_REQ(NR), .ID_W(2), .TIMEOUT(TO), .PI_2(PI2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_angle_i(req_angle), .req_ready_o(req_ready),
    .res_valid_o(res_valid), .res_ready_i(res_ready), .res_id_o(res_id),
    .res_cos_o(res_cos), .res_sin_o(res_sin),
    .res_clamped_o(res_clamped), .res_timeout_o(res_timeout),
    .core_start_o(core_start), .core_angle_o(core_angle),
    .core_cos_i(core_cos), .core_sin_i(core_sin), .core_done_i(core_done),
    .busy_o(busy)
  );

  typedef struct {
    int id;
    int ang;
    int c;
    int s;
    bit cl;
    bit to;
  } exp_t;

  exp_t sb[$];
  int   aq[NR][$];
  int   grant_log[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  bit   stub_mute = 1'b0;
  bit   idle_m = 1'b1;
  int   last_m = NR - 1;
  int   exp_start_cyc = -1;
  int   exp_valid_cyc = 32'h7fff_ffff;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int cos_of(input int a);
    return int'($cos(real'(a) / 16384.0) * 16384.0);
  endfunction

  function automatic int sin_of(input int a);
    return int'($sin(real'(a) / 16384.0) * 16384.0);
  endfunction

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Core stub: done pulse 17 cycles after the start cycle unless muted.
  logic signed [WL-1:0] stub_ang;
  logic [5:0]           stub_cnt;
  logic                 stub_act;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stub_act  <= 1'b0;
      stub_cnt  <= 6'd0;
      stub_ang  <= 16'sd0;
      core_done <= 1'b0;
      core_cos  <= 16'sd0;
      core_sin  <= 16'sd0;
    end else begin
      core_done <= 1'b0;
      if (core_start) begin
        stub_act <= 1'b1;
        stub_cnt <= 6'd0;
        stub_ang <= core_angle;
      end else if (stub_act) begin
        stub_cnt <= stub_cnt + 6'd1;
        if (stub_cnt == 6'd15) begin
          stub_act <= 1'b0;
          if (!stub_mute) begin
            core_done <= 1'b1;
            core_cos  <= 16'(cos_of(int'(stub_ang)));
            core_sin  <= 16'(sin_of(int'(stub_ang)));
          end
        end
      end
    end
  end

  // Requester driver: each requester presents the head of its angle queue.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int k = 0; k < NR; k++) begin
        if (aq[k].size() > 0) begin
          req_valid[k] = 1'b1;
          req_angle[k*WL +: WL] = 16'(aq[k][0]);
        end else begin
          req_valid[k] = 1'b0;
          req_angle[k*WL +: WL] = 16'd0;
        end
      end
    end
  end

  // Monitor: model grant/timing, check every cycle, score results.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sb.delete();
        grant_log.delete();
        idle_m        = 1'b1;
        last_m        = NR - 1;
        exp_start_cyc = -1;
        exp_valid_cyc = 32'h7fff_ffff;
      end else begin
        int   g;
        int   exp_rdy;
        exp_t e;
        g = -1;
        exp_rdy = 0;
        if (idle_m) begin
          for (int i = 0; i < NR; i++) begin
            int idx;
            idx = (last_m + 1 + i) % NR;
            if (g < 0 && req_valid[idx]) g = idx;
          end
        end
        if (g >= 0) exp_rdy = 1 << g;
        check_eq("req_ready", req_ready, exp_rdy);
        for (int i = 0; i < NR; i++) if (req_ready[i]) grant_log.push_back(i);
        check_eq("busy", busy, !idle_m);
        check_eq("core_start", core_start, cyc == exp_start_cyc);
        if (core_start && sb.size() > 0) check_eq("core_angle", core_angle, sb[0].ang);
        check_eq("res_valid", res_valid, !idle_m && cyc >= exp_valid_cyc);
        if (res_valid) begin
          if (sb.size() == 0) begin
            check_eq("res_valid_spurious", 1, 0);
          end else begin
            check_eq("res_id", res_id, sb[0].id);
            check_eq("res_cos", res_cos, sb[0].c);
            check_eq("res_sin", res_sin, sb[0].s);
            check_eq("res_clamped", res_clamped, sb[0].cl);
            check_eq("res_timeout", res_timeout, sb[0].to);
            if (res_ready) begin
              void'(sb.pop_front());
              idle_m = 1'b1;
            end
          end
        end
        if (g >= 0) begin
          e.id = g;
          e.ang = aq[g][0];
          e.cl = 1'b0;
          if (e.ang > PI2) begin
            e.ang = PI2;
            e.cl = 1'b1;
          end else if (e.ang < -PI2) begin
            e.ang = -PI2;
            e.cl = 1'b1;
          end
          e.to = stub_mute;
          e.c = stub_mute ? 0 : cos_of(e.ang);
          e.s = stub_mute ? 0 : sin_of(e.ang);
          sb.push_back(e);
          void'(aq[g].pop_front());
          last_m = g;
          idle_m = 1'b0;
          exp_start_cyc = cyc + 1;
          exp_valid_cyc = stub_mute ? cyc + TO + 2 : cyc + 19;
        end
      end
    end
  end

  task automatic push(input int k, input int a);
    @(posedge clk);
    #2;
    aq[k].push_back(a);
  endtask

  task automatic wait_drain(input string tag, input int max);
    bit done;
    done = 1'b0;
    for (int i = 0; i < max && !done; i++) begin
      @(negedge clk);
      #1;
      done = (sb.size() == 0) && idle_m && aq[0].size() == 0 && aq[1].size() == 0 &&
             aq[2].size() == 0 && aq[3].size() == 0;
    end
    check_eq(tag, done, 1);
  endtask

  task automatic check_reset_outs(input string p);
    check_eq({p, "_req_ready"}, req_ready, 0);
    check_eq({p, "_res_valid"}, res_valid, 0);
    check_eq({p, "_res_id"}, res_id, 0);
    check_eq({p, "_res_cos"}, res_cos, 0);
    check_eq({p, "_res_sin"}, res_sin, 0);
    check_eq({p, "_res_clamped"}, res_clamped, 0);
    check_eq({p, "_res_timeout"}, res_timeout, 0);
    check_eq({p, "_core_start"}, core_start, 0);
    check_eq({p, "_core_angle"}, core_angle, 0);
    check_eq({p, "_busy"}, busy, 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    for (int k = 0; k < NR; k++) aq[k].delete();
    #1;
    check_reset_outs("rst");
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    bit seen;
    int exp_order[6] = '{0, 1, 2, 3, 0, 1};
    rst_n = 1'b1;
    req_valid = '0;
    req_angle = '0;
    res_ready = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outs("por");
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;

    // Zero angle, then +/- pi/4, then clamping both directions.
    push(2, 0);
    wait_drain("drain_zero", 60);
    push(0, 12868);
    push(0, -12868);
    wait_drain("drain_pi4", 100);
    push(1, 30000);
    push(3, -32768);
    wait_drain("drain_clamp", 100);

    // Backpressure with another request pending.
    @(posedge clk);
    #2;
    res_ready = 1'b0;
    push(2, 5000);
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      seen = res_valid;
    end
    check_eq("bp_valid_seen", seen, 1);
    push(0, 100);
    repeat (10) @(posedge clk);
    #2;
    res_ready = 1'b1;
    wait_drain("drain_bp", 100);

    // Round-robin from reset with all four requesters continuously valid.
    do_reset();
    for (int k = 0; k < NR; k++) begin
      aq[k].push_back(1000 * (k + 1));
      aq[k].push_back(-1000 * (k + 1));
    end
    wait_drain("drain_rr", 400);
    check_eq("rr_log_size", grant_log.size(), 8);
    for (int i = 0; i < 6; i++) check_eq("rr_order", grant_log[i], exp_order[i]);

    // Core never answers: timeout result.
    stub_mute = 1'b1;
    push(1, 1000);
    wait_drain("drain_timeout", 120);
    stub_mute = 1'b0;

    // Reset mid-WAIT aborts; next request served normally.
    push(2, 2000);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = core_start;
    end
    check_eq("rst_start_seen", seen, 1);
    repeat (5) @(posedge clk);
    do_reset();
    push(0, 3000);
    wait_drain("drain_after_rst", 60);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
